// File: rtl/store_buffer_unit_pkg.sv
// Shared types for the store buffer unit.
//   mem_op_t      : memory operation encoding seen by the MEM stage (loads and stores).
//   store_entry_t : one buffered store {addr, wstrb, wdata} at the default bus geometry.
package store_buffer_unit_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned AW_DEF   = 32;
    localparam int unsigned NB_DEF   = XLEN_DEF / 8;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LD   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_LHU  = 4'd6,
        MEM_LWU  = 4'd7,
        MEM_SB   = 4'd8,
        MEM_SH   = 4'd9,
        MEM_SW   = 4'd10,
        MEM_SD   = 4'd11
    } mem_op_t;

    typedef struct packed {
        logic [AW_DEF-1:0]   addr;
        logic [NB_DEF-1:0]   wstrb;
        logic [XLEN_DEF-1:0] wdata;
    } store_entry_t;

endpackage

// File: rtl/store_buffer_unit_store_format.sv
// Combinational store formatter.
// Ports:
//   mem_op_i      : operation; only store ops produce a store
//   off_i         : byte offset of the store within the bus word
//   wdata_i       : right-justified store data
//   is_store_o    : op is a store this bus width supports
//   misaligned_o  : store is not naturally aligned
//   wstrb_o       : byte strobes, shifted to the offset
//   wdata_o       : data masked to the op width and shifted to the offset
module store_format
    import store_buffer_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NB   = XLEN / 8,
    parameter int unsigned OW   = $clog2(NB)
) (
    input  mem_op_t           mem_op_i,
    input  logic [OW-1:0]     off_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              is_store_o,
    output logic              misaligned_o,
    output logic [NB-1:0]     wstrb_o,
    output logic [XLEN-1:0]   wdata_o
);

    logic [NB-1:0]   w_base_strb;
    logic [XLEN-1:0] w_mask;

    always_comb begin
        w_base_strb  = '0;
        w_mask       = '0;
        is_store_o   = 1'b1;
        misaligned_o = 1'b0;
        case (mem_op_i)
            MEM_SB: begin
                w_base_strb = NB'(1);
                w_mask      = XLEN'(8'hFF);
            end
            MEM_SH: begin
                w_base_strb  = NB'(2'b11);
                w_mask       = XLEN'(16'hFFFF);
                misaligned_o = off_i[0];
            end
            MEM_SW: begin
                w_base_strb  = NB'(4'hF);
                w_mask       = XLEN'(32'hFFFF_FFFF);
                misaligned_o = |off_i[1:0];
            end
            MEM_SD: begin
                // Doubleword stores only exist on a 64-bit bus.
                if (XLEN == 64) begin
                    w_base_strb  = '1;
                    w_mask       = '1;
                    misaligned_o = |off_i;
                end else begin
                    is_store_o = 1'b0;
                end
            end
            default: is_store_o = 1'b0;
        endcase
    end

    assign wstrb_o = w_base_strb << off_i;
    assign wdata_o = (wdata_i & w_mask) << {off_i, 3'b000};

endmodule

// File: rtl/store_buffer_unit.sv
// Store buffer: formats MEM-stage stores, queues them in a DEPTH-entry FIFO and
// drains them to data memory over valid/ready. Also flags misaligned stores and
// load/store byte overlaps.
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   st_valid_i/st_ready_o        : store request handshake from the MEM stage
//   mem_op_i, waddr_i, wdata_i   : store op, byte address, right-justified data
//   misaligned_store_o/_addr_o   : one-cycle pulse and sticky address of a misaligned store
//   mem_valid_o/mem_ready_i      : head-entry handshake towards data memory
//   mem_addr_o/_wstrb_o/_wdata_o : head entry fields
//   ld_addr_i, ld_strb_i         : load in the MEM stage
//   ld_hit_o                     : load overlaps a buffered store
//   empty_o                      : buffer holds no stores
module store_buffer_unit
    import store_buffer_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  mem_op_t             mem_op_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                misaligned_store_o,
    output logic [AW-1:0]       misaligned_addr_o,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [AW-1:0]       mem_addr_o,
    output logic [XLEN/8-1:0]   mem_wstrb_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic [AW-1:0]       ld_addr_i,
    input  logic [XLEN/8-1:0]   ld_strb_i,
    output logic                ld_hit_o,
    output logic                empty_o
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned PW = $clog2(DEPTH);

    // Width-matched copy of store_entry_t for this instance's bus geometry.
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [NB-1:0]   wstrb;
        logic [XLEN-1:0] wdata;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW:0]     r_wptr;
    logic [PW:0]     r_rptr;
    logic            r_mis_pulse;
    logic [AW-1:0]   r_mis_addr;

    logic            w_is_store;
    logic            w_misaligned;
    logic [NB-1:0]   w_fmt_strb;
    logic [XLEN-1:0] w_fmt_data;
    logic [AW-1:0]   w_align_mask;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [PW-1:0]   w_widx;
    logic [PW-1:0]   w_ridx;
    logic [DEPTH-1:0] w_valid_nxt;
    entry_t          w_new_entry;
    entry_t          w_head;
    logic [AW-1:0]   w_ld_word;

    store_format #(
        .XLEN (XLEN)
    ) u_store_format (
        .mem_op_i     (mem_op_i),
        .off_i        (waddr_i[OW-1:0]),
        .wdata_i      (wdata_i),
        .is_store_o   (w_is_store),
        .misaligned_o (w_misaligned),
        .wstrb_o      (w_fmt_strb),
        .wdata_o      (w_fmt_data)
    );

    assign w_align_mask = ~AW'(NB - 1);

    assign w_widx  = r_wptr[PW-1:0];
    assign w_ridx  = r_rptr[PW-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (w_widx == w_ridx);

    // No bypass when full: a pop in the same cycle does not open a slot.
    assign st_ready_o = !w_full;
    assign w_accept   = st_valid_i && st_ready_o && w_is_store;
    // Misaligned stores complete the handshake but are dropped.
    assign w_push     = w_accept && !w_misaligned;
    assign w_pop      = !w_empty && mem_ready_i;

    assign w_new_entry.addr  = waddr_i & w_align_mask;
    assign w_new_entry.wstrb = w_fmt_strb;
    assign w_new_entry.wdata = w_fmt_data;

    // Push and pop never target the same slot: that needs full (no push) or empty (no pop).
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_pop) begin
            w_valid_nxt[w_ridx] = 1'b0;
        end
        if (w_push) begin
            w_valid_nxt[w_widx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_valid     <= '0;
            r_mis_pulse <= 1'b0;
            r_mis_addr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[w_widx] <= w_new_entry;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_valid     <= w_valid_nxt;
            r_mis_pulse <= w_accept && w_misaligned;
            if (w_accept && w_misaligned) begin
                r_mis_addr <= waddr_i;
            end
        end
    end

    assign w_head      = r_mem[w_ridx];
    assign mem_valid_o = !w_empty;
    assign mem_addr_o  = w_head.addr;
    assign mem_wstrb_o = w_head.wstrb;
    assign mem_wdata_o = w_head.wdata;
    assign empty_o     = w_empty;

    assign misaligned_store_o = r_mis_pulse;
    assign misaligned_addr_o  = r_mis_addr;

    // Only registered entries are compared, so a store enqueued this cycle never hits.
    assign w_ld_word = ld_addr_i & w_align_mask;
    always_comb begin
        ld_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_mem[i].addr == w_ld_word) &&
                ((r_mem[i].wstrb & ld_strb_i) != '0)) begin
                ld_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer_unit.sv
module tb_store_buffer_unit;
    import store_buffer_unit_pkg::*;

    logic clk;
    logic rst;

    // 32-bit instance
    logic        st_valid;
    logic        st_ready;
    mem_op_t     mem_op;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        mis;
    logic [31:0] mis_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] ld_addr;
    logic [3:0]  ld_strb;
    logic        ld_hit;
    logic        empty;

    // 64-bit instance
    logic        st_valid64;
    logic        st_ready64;
    mem_op_t     mem_op64;
    logic [31:0] waddr64;
    logic [63:0] wdata64;
    logic        mis64;
    logic [31:0] mis_addr64;
    logic        mem_valid64;
    logic        mem_ready64;
    logic [31:0] mem_addr64;
    logic [7:0]  mem_wstrb64;
    logic [63:0] mem_wdata64;
    logic [31:0] ld_addr64;
    logic [7:0]  ld_strb64;
    logic        ld_hit64;
    logic        empty64;

    int n_checks = 0;
    int n_fails  = 0;

    store_buffer_unit #(.XLEN(32), .AW(32), .DEPTH(4)) u_dut32 (
        .clk_i              (clk),
        .rst_i              (rst),
        .st_valid_i         (st_valid),
        .st_ready_o         (st_ready),
        .mem_op_i           (mem_op),
        .waddr_i            (waddr),
        .wdata_i            (wdata),
        .misaligned_store_o (mis),
        .misaligned_addr_o  (mis_addr),
        .mem_valid_o        (mem_valid),
        .mem_ready_i        (mem_ready),
        .mem_addr_o         (mem_addr),
        .mem_wstrb_o        (mem_wstrb),
        .mem_wdata_o        (mem_wdata),
        .ld_addr_i          (ld_addr),
        .ld_strb_i          (ld_strb),
        .ld_hit_o           (ld_hit),
        .empty_o            (empty)
    );

    store_buffer_unit #(.XLEN(64), .AW(32), .DEPTH(4)) u_dut64 (
        .clk_i              (clk),
        .rst_i              (rst),
        .st_valid_i         (st_valid64),
        .st_ready_o         (st_ready64),
        .mem_op_i           (mem_op64),
        .waddr_i            (waddr64),
        .wdata_i            (wdata64),
        .misaligned_store_o (mis64),
        .misaligned_addr_o  (mis_addr64),
        .mem_valid_o        (mem_valid64),
        .mem_ready_i        (mem_ready64),
        .mem_addr_o         (mem_addr64),
        .mem_wstrb_o        (mem_wstrb64),
        .mem_wdata_o        (mem_wdata64),
        .ld_addr_i          (ld_addr64),
        .ld_strb_i          (ld_strb64),
        .ld_hit_o           (ld_hit64),
        .empty_o            (empty64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive32(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        mem_op   = op;
        waddr    = a;
        wdata    = d;
    endtask

    initial begin
        rst        = 1'b1;
        st_valid   = 1'b0;
        mem_op     = MEM_NONE;
        waddr      = '0;
        wdata      = '0;
        mem_ready  = 1'b0;
        ld_addr    = '0;
        ld_strb    = '0;
        st_valid64 = 1'b0;
        mem_op64   = MEM_NONE;
        waddr64    = '0;
        wdata64    = '0;
        mem_ready64 = 1'b0;
        ld_addr64  = '0;
        ld_strb64  = '0;

        // Reset state
        #1;
        check("rst_st_ready", st_ready, 1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_mis", mis, 0);
        check("rst_mis_addr", mis_addr, 0);
        check("rst_ld_hit", ld_hit, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // SB at 0x1003; store in flight does not count as a hazard
        @(negedge clk);
        drive32(MEM_SB, 32'h1003, 32'h1234_56AB);
        ld_addr = 32'h1000;
        ld_strb = 4'b1000;
        #1;
        check("sb_inflight_hit", ld_hit, 0);
        check("sb_inflight_empty", empty, 1);
        @(negedge clk);
        st_valid = 1'b0;
        check("sb_valid", mem_valid, 1);
        check("sb_addr", mem_addr, 32'h1000);
        check("sb_wstrb", mem_wstrb, 4'b1000);
        check("sb_wdata", mem_wdata, 32'hAB00_0000);
        check("sb_hit", ld_hit, 1);
        ld_strb = 4'b0011;
        #1;
        check("sb_nohit_strb", ld_hit, 0);
        ld_addr = 32'h1004;
        ld_strb = 4'b1000;
        #1;
        check("sb_nohit_addr", ld_hit, 0);
        ld_addr = 32'h1000;
        mem_ready = 1'b1;
        #1;
        check("sb_hit_popping", ld_hit, 1);
        @(negedge clk);
        mem_ready = 1'b0;
        check("sb_drained", empty, 1);
        check("sb_nohit_after", ld_hit, 0);

        // Misaligned SH at 0x2001
        drive32(MEM_SH, 32'h2001, 32'h0000_BEEF);
        #1;
        check("sh_mis_ready", st_ready, 1);
        @(negedge clk);
        st_valid = 1'b0;
        check("sh_mis_empty", empty, 1);
        check("sh_mis_pulse", mis, 1);
        check("sh_mis_addr", mis_addr, 32'h2001);
        @(negedge clk);
        check("sh_mis_pulse_end", mis, 0);
        check("sh_mis_addr_held", mis_addr, 32'h2001);

        // Fill with mem_ready low: five SWs, the fifth waits for the first pop
        for (int k = 0; k < 4; k++) begin
            drive32(MEM_SW, 32'h3000 + 32'(4 * k), 32'(k + 1));
            @(negedge clk);
        end
        drive32(MEM_SW, 32'h3010, 32'd5);
        check("fill_full_ready", st_ready, 0);
        @(negedge clk);
        check("fill_held_ready", st_ready, 0);
        check("fill_head_addr", mem_addr, 32'h3000);
        check("fill_head_data", mem_wdata, 32'd1);
        mem_ready = 1'b1;
        #1;
        check("fill_no_bypass", st_ready, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        check("fill_after_pop_ready", st_ready, 1);
        check("fill_head2_addr", mem_addr, 32'h3004);
        @(negedge clk);
        st_valid = 1'b0;
        check("fill_full_again", st_ready, 0);
        mem_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check("drain_valid", mem_valid, 1);
            check("drain_addr", mem_addr, 32'h3000 + 32'(4 * k));
            check("drain_data", mem_wdata, 32'(k + 1));
            check("drain_wstrb", mem_wstrb, 4'hF);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_valid_low", mem_valid, 0);

        // SD is not a store on a 32-bit bus; aligned SH masks upper data bits
        drive32(MEM_SD, 32'h4000, 32'hFFFF_FFFF);
        @(negedge clk);
        check("sd32_not_queued", empty, 1);
        check("sd32_no_mis", mis, 0);
        drive32(MEM_SH, 32'h1002, 32'hFFFF_BEEF);
        @(negedge clk);
        st_valid = 1'b0;
        check("sh_addr", mem_addr, 32'h1000);
        check("sh_wstrb", mem_wstrb, 4'b1100);
        check("sh_wdata", mem_wdata, 32'hBEEF_0000);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("sh_drained", empty, 1);

        // Reset with three entries pending
        for (int k = 0; k < 3; k++) begin
            drive32(MEM_SW, 32'h5000 + 32'(4 * k), 32'hA0 + 32'(k));
            @(negedge clk);
        end
        st_valid = 1'b0;
        check("pre_rst_valid", mem_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", mem_valid, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_ready", st_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_valid", mem_valid, 0);
        check("post_rst_empty", empty, 1);
        check("post_rst_addr", mem_addr, 0);
        mem_ready = 1'b0;

        // 64-bit bus: SW at 0x10C then SD at 0x200
        st_valid64 = 1'b1;
        mem_op64   = MEM_SW;
        waddr64    = 32'h10C;
        wdata64    = 64'h0000_0000_1122_3344;
        @(negedge clk);
        mem_op64   = MEM_SD;
        waddr64    = 32'h200;
        wdata64    = 64'h0102_0304_0506_0708;
        check("sw64_addr", mem_addr64, 32'h108);
        check("sw64_wstrb", mem_wstrb64, 8'hF0);
        check("sw64_wdata", mem_wdata64, 64'h1122_3344_0000_0000);
        @(negedge clk);
        st_valid64  = 1'b0;
        mem_ready64 = 1'b1;
        @(negedge clk);
        mem_ready64 = 1'b0;
        check("sd64_addr", mem_addr64, 32'h200);
        check("sd64_wstrb", mem_wstrb64, 8'hFF);
        check("sd64_wdata", mem_wdata64, 64'h0102_0304_0506_0708);
        ld_addr64 = 32'h204;
        ld_strb64 = 8'h10;
        #1;
        check("sd64_hit", ld_hit64, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
- Parametrised successor to the single-cycle store formatter: formats SB/SH/SW/SD stores for an XLEN-wide data bus and detects misaligned stores.
- Queues committed stores in a DEPTH-entry FIFO and drains them to data memory over a valid/ready handshake.
- Reports load/store byte-overlap hazards so the pipeline can stall loads.
- Sits between the MEM stage and the data memory port.

Parameters:
- XLEN, 32, data bus width in bits; legal values 32 or 64.
- AW, 32, byte address width.
- DEPTH, 4, number of store buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- st_valid_i  in  1  store request from the MEM stage.
- st_ready_o  out  1  buffer can accept a store.
- mem_op_i  in  mem_op_t  store type: MEM_SB, MEM_SH, MEM_SW or MEM_SD; other values mean no store.
- waddr_i  in  AW  store byte address.
- wdata_i  in  XLEN  unformatted store data, right-justified.
- misaligned_store_o  out  1  one-cycle pulse: the previous accepted store was misaligned.
- misaligned_addr_o  out  AW  address of the last misaligned store.
- mem_valid_o  out  1  head entry is presented to memory.
- mem_ready_i  in  1  memory accepts the head entry.
- mem_addr_o  out  AW  bus-aligned address of the head entry.
- mem_wstrb_o  out  XLEN/8  byte strobes of the head entry.
- mem_wdata_o  out  XLEN  formatted data of the head entry.
- ld_addr_i  in  AW  address of the load in the MEM stage.
- ld_strb_i  in  XLEN/8  byte strobes of that load, relative to the bus-aligned word.
- ld_hit_o  out  1  load overlaps a buffered store.
- empty_o  out  1  no buffered stores; used for fence and drain.

Behaviour:
- Reset: all entries invalid; pointers cleared.
  - Outputs: st_ready_o=1, mem_valid_o=0, empty_o=1, misaligned_store_o=0, misaligned_addr_o=0, ld_hit_o=0, mem_addr_o/mem_wstrb_o/mem_wdata_o=0.
- Handshake: a store is accepted when st_valid_i && st_ready_o && mem_op_i is a store op.
- st_ready_o = !full. There is no same-cycle bypass when full, even if memory pops that cycle.
- Formatting: NB=XLEN/8, off=waddr_i[log2(NB)-1:0].
  - MEM_SB: strobe 1<<off, data<<8*off.
  - MEM_SH: strobe 3<<off, data<<8*off; legal only when off[0]=0.
  - MEM_SW: strobe 4'hF<<off, data<<8*off; legal only when off[1:0]=0.
  - MEM_SD: only when XLEN=64; strobe all ones, legal only when off=0.
  - MEM_SD with XLEN=32 is treated as no store and is not accepted.
  - Data is masked to the op width before shifting.
  - Stored address = waddr_i with the low log2(NB) bits zeroed.
- Misaligned store:
  - The store is consumed (handshake completes) but is not enqueued.
  - The cycle after acceptance: misaligned_store_o=1 for exactly one cycle; misaligned_addr_o = the full waddr_i, held until the next misaligned store.
- FIFO:
  - Write and read pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full = MSBs differ and the other bits are equal; empty = pointers equal.
  - Simultaneous push and pop leaves the count unchanged; this is legal at any fill level except full, where push is blocked.
- Latency: an entry accepted in cycle N gives mem_valid_o=1 in cycle N+1 at the earliest.
- Memory side:
  - mem_valid_o = !empty; the head fields are driven from the registered entry.
  - Pop occurs on mem_valid_o && mem_ready_i.
  - mem_valid_o stays high and the head fields stay stable until the pop; no retraction.
- Hazard: ld_hit_o is combinational. It is 1 when any valid entry has addr == bus-aligned ld_addr_i and (entry wstrb & ld_strb_i) != 0.
  - An entry popping this cycle still counts as a hit.
  - A store being enqueued this cycle does not count.
- empty_o mirrors the FIFO empty flag.
- Reset mid-operation clears all entries immediately; pending stores are discarded and mem_valid_o drops asynchronously.

Decomposition:
- params_pkg:
  - extend mem_op_t with MEM_SD;
  - add a store_entry_t struct {addr, wstrb, wdata} parametrised via XLEN/AW localparams.
- One sub-module, store_format: purely combinational, computes strobes, shifted data and the misaligned flag from mem_op_i, the offset and wdata_i.
- store_buffer_unit instantiates store_format and holds the FIFO, pointers, misaligned registers and hazard comparators.

Test Plan:
- XLEN=32, SB at 0x1003, data 0xAB -> one cycle later: mem_valid_o=1, mem_addr_o=0x1000, mem_wstrb_o=4'b1000, mem_wdata_o=0xAB000000.
- XLEN=32, SH at 0x2001 -> entry not enqueued, empty_o stays 1; next cycle misaligned_store_o=1 for one cycle, misaligned_addr_o=0x2001.
- XLEN=64, SW at 0x10C, data 0x11223344 -> mem_addr_o=0x108, mem_wstrb_o=8'hF0, mem_wdata_o=0x11223344_00000000.
- DEPTH=4, mem_ready_i=0, five stores back-to-back -> st_ready_o=0 after the fourth; the fifth is held and accepted the cycle after the first pop. Order is preserved at the memory port across pointer wrap-around.
- Buffered SB at 0x1003; load with ld_addr_i=0x1000 -> ld_strb_i=4'b1000 gives ld_hit_o=1; ld_strb_i=4'b0011 gives ld_hit_o=0.
- Assert rst_i with 3 entries pending -> mem_valid_o=0, empty_o=1, st_ready_o=1 without a clock edge; after release, no stale entries appear at the memory port.
